// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shift_unit
//  Description : Multi-cycle shift engine. Applies one single-bit step of a
//                pass / LSL / LSR / ASR operation per clock, for 0..2^CNTW-1
//                steps, under a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_unit #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNTW-1:0]  amount,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] c_op_pass = 2'b00;
  localparam logic [1:0] c_op_lsl  = 2'b01;
  localparam logic [1:0] c_op_lsr  = 2'b10;
  localparam logic [1:0] c_op_asr  = 2'b11;

  localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sout_q, sout_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] w_step;

  // One single-bit step of the latched operation applied to the working value.
  always_comb begin
    w_step = sout_q;
    case (op_q)
      c_op_pass: w_step = sout_q;
      c_op_lsl:  w_step = {sout_q[WIDTH-2:0], 1'b0};
      c_op_lsr:  w_step = {1'b0, sout_q[WIDTH-1:1]};
      c_op_asr:  w_step = {sout_q[WIDTH-1], sout_q[WIDTH-1:1]};
      default:   w_step = sout_q;
    endcase
  end

  // Next-state logic: accept in IDLE/DONE, step-and-count in SHIFT.
  always_comb begin
    state_d = state_q;
    sout_d  = sout_q;
    count_d = count_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sout_d  = in;
          op_d    = op;
          count_d = amount;
          state_d = (amount != '0) ? ST_SHIFT : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // start is ignored here; the latched request runs to completion.
        sout_d  = w_step;
        count_d = count_q - c_cnt_one;
        if (count_q == c_cnt_one) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sout_q  <= '0;
      count_q <= '0;
      op_q    <= c_op_pass;
    end else begin
      state_q <= state_d;
      sout_q  <= sout_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  assign sout = sout_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

endmodule
`default_nettype wire
